// File: rtl/counter_seq_pkg.sv
// Shared types and constants for the counter sequence driver.
package counter_seq_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    VERIFY,
    RUN,
    FINISH
  } state_e;

endpackage

// File: rtl/counter_seq_pace.sv
// Step pacing down-counter: reloads to STEP_DIV-1 and raises tick when it reaches zero.
module counter_seq_pace #(
  parameter int STEP_DIV = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic reload,
  input  logic dec,
  output logic tick
);

  localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PW-1:0] RELOAD_VAL = PW'(STEP_DIV - 1);

  logic [PW-1:0] pace_q;
  logic [PW-1:0] pace_d;

  always_comb begin
    pace_d = pace_q;
    if (reload) begin
      pace_d = RELOAD_VAL;
    end else if (dec && (pace_q != '0)) begin
      pace_d = pace_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pace_q <= '0;
    end else begin
      pace_q <= pace_d;
    end
  end

  assign tick = (pace_q == '0);

endmodule

// File: rtl/counter_seq_driver.sv
// Sequencer that loads the up/down counter, steps it to end_val and checks its readback.
// Readback comparison is enabled by defining COUNTER_SEQ_READBACK_CHECK_EN.
module counter_seq_driver
  import counter_seq_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int STEP_DIV = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] start_val,
  input  logic [WIDTH-1:0] end_val,
  input  logic [WIDTH-1:0] y_in,
  output logic             cnt_en,
  output logic             cnt_load,
  output logic             cnt_up,
  output logic             cnt_oe,
  output logic [WIDTH-1:0] cnt_d,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] end_q, end_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             up_q, up_d;
  logic             err_q, err_d;
  logic             cnt_load_q, cnt_load_d;
  logic             cnt_up_q, cnt_up_d;
  logic             cnt_oe_q, cnt_oe_d;
  logic [WIDTH-1:0] cnt_d_q, cnt_d_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             step_c;
  logic             pace_reload;
  logic             pace_tick;
  logic             mismatch;

`ifdef COUNTER_SEQ_READBACK_CHECK_EN
  assign mismatch = (y_in != shadow_q);
`else
  logic unused_y_in;
  assign unused_y_in = ^y_in;
  assign mismatch    = 1'b0;
`endif

  counter_seq_pace #(
    .STEP_DIV(STEP_DIV)
  ) u_pace (
    .clk    (clk),
    .reset_n(reset_n),
    .reload (pace_reload),
    .dec    (state_q == RUN),
    .tick   (pace_tick)
  );

  always_comb begin
    state_d     = state_q;
    start_d     = start_q;
    end_d       = end_q;
    up_d        = up_q;
    shadow_d    = shadow_q;
    err_d       = err_q;
    step_c      = 1'b0;
    pace_reload = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          start_d = start_val;
          end_d   = end_val;
          up_d    = (end_val >= start_val);
          err_d   = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        shadow_d = start_q;
        state_d  = VERIFY;
      end
      VERIFY: begin
        if (mismatch) begin
          err_d   = 1'b1;
          state_d = FINISH;
        end else if (shadow_q == end_q) begin
          state_d = FINISH;
        end else begin
          pace_reload = 1'b1;
          state_d     = RUN;
        end
      end
      RUN: begin
        if (mismatch) begin
          err_d   = 1'b1;
          state_d = FINISH;
        end else if (shadow_q == end_q) begin
          state_d = FINISH;
        end else if (pace_tick) begin
          // The counter moves on this edge, so the shadow moves with it.
          step_c      = 1'b1;
          shadow_d    = up_q ? (shadow_q + WIDTH'(1)) : (shadow_q - WIDTH'(1));
          pace_reload = 1'b1;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Registered pin outputs are decoded from the state being entered.
    cnt_load_d = (state_d == LOAD);
    cnt_d_d    = (state_d == LOAD) ? start_d : '0;
    cnt_oe_d   = (state_d == VERIFY) || (state_d == RUN);
    cnt_up_d   = (state_d == RUN) && up_d;
    busy_d     = (state_d == LOAD) || (state_d == VERIFY) || (state_d == RUN);
    done_d     = (state_d == FINISH);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      start_q    <= '0;
      end_q      <= '0;
      up_q       <= 1'b0;
      shadow_q   <= '0;
      err_q      <= 1'b0;
      cnt_load_q <= 1'b0;
      cnt_up_q   <= 1'b0;
      cnt_oe_q   <= 1'b0;
      cnt_d_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      end_q      <= end_d;
      up_q       <= up_d;
      shadow_q   <= shadow_d;
      err_q      <= err_d;
      cnt_load_q <= cnt_load_d;
      cnt_up_q   <= cnt_up_d;
      cnt_oe_q   <= cnt_oe_d;
      cnt_d_q    <= cnt_d_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign cnt_en   = step_c;
  assign cnt_load = cnt_load_q;
  assign cnt_up   = cnt_up_q;
  assign cnt_oe   = cnt_oe_q;
  assign cnt_d    = cnt_d_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_counter_seq_driver.sv
// Directed bench for counter_seq_driver with a behavioural up/down counter on each instance.
module tb_counter_seq_driver;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       start = 1'b0;
  logic       sel3 = 1'b0;
  logic [7:0] start_val = 8'h00;
  logic [7:0] end_val = 8'h00;
  logic       ovr = 1'b0;
  logic [7:0] ovr_val = 8'h00;

  int checks = 0;
  int errors = 0;

  logic       en1, load1, up1, oe1, busy1, done1, err1;
  logic       en3, load3, up3, oe3, busy3, done3, err3;
  logic [7:0] d1, d3, cnt1, cnt3, y1, y3;

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt1 <= 8'h00;
    else if (load1) cnt1 <= d1;
    else if (en1) cnt1 <= up1 ? cnt1 + 8'd1 : cnt1 - 8'd1;
  end
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt3 <= 8'h00;
    else if (load3) cnt3 <= d3;
    else if (en3) cnt3 <= up3 ? cnt3 + 8'd1 : cnt3 - 8'd1;
  end
  assign y1 = ovr ? ovr_val : cnt1;
  assign y3 = ovr ? ovr_val : cnt3;

  counter_seq_driver #(.WIDTH(8), .STEP_DIV(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start & ~sel3), .start_val(start_val),
    .end_val(end_val), .y_in(y1), .cnt_en(en1), .cnt_load(load1), .cnt_up(up1),
    .cnt_oe(oe1), .cnt_d(d1), .busy(busy1), .done(done1), .err(err1)
  );

  counter_seq_driver #(.WIDTH(8), .STEP_DIV(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .start(start & sel3), .start_val(start_val),
    .end_val(end_val), .y_in(y3), .cnt_en(en3), .cnt_load(load3), .cnt_up(up3),
    .cnt_oe(oe3), .cnt_d(d3), .busy(busy3), .done(done3), .err(err3)
  );

  logic       o_en, o_load, o_up, o_oe, o_busy, o_done, o_err;
  logic [7:0] o_d, o_cnt;
  assign o_en   = sel3 ? en3 : en1;
  assign o_load = sel3 ? load3 : load1;
  assign o_up   = sel3 ? up3 : up1;
  assign o_oe   = sel3 ? oe3 : oe1;
  assign o_busy = sel3 ? busy3 : busy1;
  assign o_done = sel3 ? done3 : done1;
  assign o_err  = sel3 ? err3 : err1;
  assign o_d    = sel3 ? d3 : d1;
  assign o_cnt  = sel3 ? cnt3 : cnt1;

  // Observations gathered by run_seq; cycle 1 is the first cycle after the accept edge.
  int         obs_done_cyc, obs_done_cnt, obs_pulses, obs_first_pulse;
  int         obs_spacing_bad, obs_up_bad, obs_overlap, obs_load_cnt;
  logic [7:0] obs_load_d, obs_y;
  logic       obs_err_at_done, obs_busy_at_done, obs_en_at_ovr, obs_oe_verify;

  task automatic run_seq(input logic s3, input logic [7:0] sv, input logic [7:0] ev,
                         input int step, input int ovr_cyc, input logic [7:0] ov,
                         input int busy_cyc, input int max_cyc);
    int prev;
    logic exp_up;
    exp_up = (ev >= sv);
    prev = -1;
    obs_done_cyc = -1; obs_done_cnt = 0; obs_pulses = 0; obs_first_pulse = -1;
    obs_spacing_bad = 0; obs_up_bad = 0; obs_overlap = 0; obs_load_cnt = 0;
    obs_load_d = 8'h00; obs_err_at_done = 1'b0; obs_busy_at_done = 1'b1;
    obs_en_at_ovr = 1'b1; obs_oe_verify = 1'b0;
    @(negedge clk);
    sel3 = s3; start_val = sv; end_val = ev; start = 1'b1; ovr_val = ov;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= max_cyc; i++) begin
      ovr = (i == ovr_cyc);
      if (i == busy_cyc) begin
        start = 1'b1; start_val = ~sv; end_val = ~ev;
      end else begin
        start = 1'b0;
      end
      #1;
      if (o_en) begin
        obs_pulses++;
        if (o_up !== exp_up) obs_up_bad++;
        if (prev < 0) obs_first_pulse = i;
        else if (i - prev != step) obs_spacing_bad++;
        prev = i;
      end
      if (o_load) begin
        obs_load_cnt++;
        obs_load_d = o_d;
      end
      if (o_load && o_en) obs_overlap++;
      if (i == 2) obs_oe_verify = o_oe;
      if (i == ovr_cyc) obs_en_at_ovr = o_en;
      if (o_done) begin
        obs_done_cnt++;
        obs_done_cyc = i;
        obs_err_at_done = o_err;
        obs_busy_at_done = o_busy;
      end
      obs_y = o_cnt;
      @(posedge clk);
    end
    #1 ovr = 1'b0; start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy1 || busy3) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (busy1 || busy3) begin
      errors++;
      $display("FAIL idle_timeout: busy1=%0b busy3=%0b required 0", busy1, busy3);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({en1, load1, up1, oe1, d1, busy1, done1, err1} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required all zero",
               {en1, load1, up1, oe1, d1, busy1, done1, err1});
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_up();
    run_seq(1'b0, 8'h03, 8'h07, 1, 0, 8'h00, 0, 11);
    checks++;
    if (obs_pulses !== 4) begin errors++; $display("FAIL up_pulses: got %0d required 4", obs_pulses); end
    checks++;
    if (obs_first_pulse !== 3 || obs_spacing_bad !== 0 || obs_up_bad !== 0) begin
      errors++;
      $display("FAIL up_pulse_shape: first=%0d spacing_bad=%0d up_bad=%0d required 3/0/0",
               obs_first_pulse, obs_spacing_bad, obs_up_bad);
    end
    checks++;
    if (obs_load_cnt !== 1 || obs_load_d !== 8'h03 || obs_overlap !== 0) begin
      errors++;
      $display("FAIL up_load: count=%0d d=%h overlap=%0d required 1/03/0",
               obs_load_cnt, obs_load_d, obs_overlap);
    end
    checks++;
    if (obs_done_cyc !== 8 || obs_done_cnt !== 1) begin
      errors++;
      $display("FAIL up_done: cycle=%0d pulses=%0d required 8/1", obs_done_cyc, obs_done_cnt);
    end
    checks++;
    if (obs_err_at_done !== 1'b0 || obs_busy_at_done !== 1'b0 || obs_y !== 8'h07 || obs_oe_verify !== 1'b1) begin
      errors++;
      $display("FAIL up_final: err=%0b busy=%0b y=%h oe_verify=%0b required 0/0/07/1",
               obs_err_at_done, obs_busy_at_done, obs_y, obs_oe_verify);
    end
    wait_idle();
    checks++;
    if ({o_en, o_load, o_oe, o_up, o_d} !== 12'd0) begin
      errors++;
      $display("FAIL up_idle_pins: got %b required zero", {o_en, o_load, o_oe, o_up, o_d});
    end
  endtask

  task automatic test_down_paced();
    run_seq(1'b1, 8'hF0, 8'hEC, 3, 0, 8'h00, 0, 19);
    checks++;
    if (obs_pulses !== 4 || obs_first_pulse !== 5 || obs_spacing_bad !== 0) begin
      errors++;
      $display("FAIL down_pulses: n=%0d first=%0d spacing_bad=%0d required 4/5/0",
               obs_pulses, obs_first_pulse, obs_spacing_bad);
    end
    checks++;
    if (obs_up_bad !== 0 || obs_done_cyc !== 16 || obs_y !== 8'hEC || obs_err_at_done !== 1'b0) begin
      errors++;
      $display("FAIL down_done: up_bad=%0d done=%0d y=%h err=%0b required 0/16/ec/0",
               obs_up_bad, obs_done_cyc, obs_y, obs_err_at_done);
    end
    wait_idle();
  endtask

  task automatic test_equal();
    run_seq(1'b0, 8'h55, 8'h55, 1, 0, 8'h00, 0, 6);
    checks++;
    if (obs_pulses !== 0 || obs_load_cnt !== 1 || obs_done_cyc !== 3 || obs_y !== 8'h55) begin
      errors++;
      $display("FAIL equal: pulses=%0d loads=%0d done=%0d y=%h required 0/1/3/55",
               obs_pulses, obs_load_cnt, obs_done_cyc, obs_y);
    end
    checks++;
    if (obs_err_at_done !== 1'b0) begin
      errors++;
      $display("FAIL equal_err_clear: err=%0b required 0", obs_err_at_done);
    end
    wait_idle();
  endtask

  task automatic test_mismatch();
    logic exp_err;
    int   exp_pulses, exp_done;
    logic [7:0] exp_y;
`ifdef COUNTER_SEQ_READBACK_CHECK_EN
    exp_err = 1'b1; exp_pulses = 2; exp_done = 6; exp_y = 8'h05;
`else
    exp_err = 1'b0; exp_pulses = 4; exp_done = 8; exp_y = 8'h07;
`endif
    run_seq(1'b0, 8'h03, 8'h07, 1, 5, 8'h06, 0, 11);
    checks++;
    if (obs_err_at_done !== exp_err || obs_done_cyc !== exp_done || obs_done_cnt !== 1) begin
      errors++;
      $display("FAIL mismatch_done: err=%0b done=%0d n=%0d required %0b/%0d/1",
               obs_err_at_done, obs_done_cyc, obs_done_cnt, exp_err, exp_done);
    end
    checks++;
    if (obs_pulses !== exp_pulses || obs_en_at_ovr !== ~exp_err || obs_y !== exp_y) begin
      errors++;
      $display("FAIL mismatch_en: pulses=%0d en_at_fault=%0b y=%h required %0d/%0b/%h",
               obs_pulses, obs_en_at_ovr, obs_y, exp_pulses, ~exp_err, exp_y);
    end
    wait_idle();
    repeat (3) @(negedge clk);
    checks++;
    if (err1 !== exp_err) begin
      errors++;
      $display("FAIL mismatch_sticky: err=%0b required %0b", err1, exp_err);
    end
  endtask

  task automatic test_back_to_back();
    run_seq(1'b0, 8'h10, 8'h12, 1, 0, 8'h00, 4, 9);
    checks++;
    if (obs_pulses !== 2 || obs_done_cyc !== 6 || obs_done_cnt !== 1 || obs_y !== 8'h12) begin
      errors++;
      $display("FAIL busy_start: pulses=%0d done=%0d n=%0d y=%h required 2/6/1/12",
               obs_pulses, obs_done_cyc, obs_done_cnt, obs_y);
    end
    wait_idle();
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    sel3 = 1'b0; start_val = 8'h00; end_val = 8'hFF; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({en1, load1, up1, oe1, d1, busy1, done1, err1} !== 15'd0) begin
      errors++;
      $display("FAIL reset_mid_run: got %b required all zero",
               {en1, load1, up1, oe1, d1, busy1, done1, err1});
    end
    repeat (2) @(negedge clk);
    checks++;
    if (done1 !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_done: done=%0b busy=%0b required 0/0", done1, busy1);
    end
    reset_n = 1'b1;
    @(negedge clk);
    run_seq(1'b0, 8'h03, 8'h07, 1, 0, 8'h00, 0, 11);
    checks++;
    if (obs_pulses !== 4 || obs_done_cyc !== 8 || obs_y !== 8'h07) begin
      errors++;
      $display("FAIL restart: pulses=%0d done=%0d y=%h required 4/8/07",
               obs_pulses, obs_done_cyc, obs_y);
    end
    wait_idle();
  endtask

  task automatic test_full_range();
    run_seq(1'b0, 8'h00, 8'hFF, 1, 0, 8'h00, 0, 262);
    checks++;
    if (obs_pulses !== 255 || obs_up_bad !== 0 || obs_spacing_bad !== 0) begin
      errors++;
      $display("FAIL full_pulses: n=%0d up_bad=%0d spacing_bad=%0d required 255/0/0",
               obs_pulses, obs_up_bad, obs_spacing_bad);
    end
    checks++;
    if (obs_done_cyc !== 259 || obs_y !== 8'hFF || obs_err_at_done !== 1'b0) begin
      errors++;
      $display("FAIL full_done: done=%0d y=%h err=%0b required 259/ff/0",
               obs_done_cyc, obs_y, obs_err_at_done);
    end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_up();
    test_down_paced();
    test_mismatch();
    test_equal();
    test_back_to_back();
    test_reset_mid_run();
    test_full_range();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
